i2s_word_rx: RTL and testbench

- Upstream front end of the I2S-to-LED streamer; runs on i2s_clk and deserialises the Philips-format I2S stream (i2s_ws, i2s_data) into parallel words.
- Detects an in-band frame sync word, tracks lock, and numbers every data word within a frame.
- Delivers words with a one-cycle valid strobe to the downstream pixel mask / LED scan stage, which selects its tile by word index.

---
 rtl/i2s_pkg.sv | 18 +
 rtl/i2s_slot_shifter.sv | 63 ++++++
 rtl/i2s_word_rx.sv | 116 +++++++++++
 tb/tb_i2s_word_rx.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants and types for the I2S receive front end and the
// downstream mask stage.
package i2s_pkg;

  localparam int          I2S_WORD_W    = 32;
  localparam int          I2S_IDX_W     = 16;
  localparam logic [31:0] I2S_SYNC_WORD = 32'hA5A5_5A5A;

  localparam logic CHAN_LEFT  = 1'b0;
  localparam logic CHAN_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    RX_UNPRIMED = 2'd0,
    RX_HUNT     = 2'd1,
    RX_LOCKED   = 2'd2
  } rx_state_e;

endpackage

// File: rtl/i2s_slot_shifter.sv
// Collects serial bits of one I2S slot and presents the MSB-aligned word,
// its length and its channel on the WS-change edge that ends the slot.
module i2s_slot_shifter
  import i2s_pkg::*;
#(
  parameter int WORD_W = I2S_WORD_W,
  parameter int CNT_W  = $clog2(WORD_W + 2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i2s_ws,
  input  logic              i2s_data,
  output logic              slot_done,
  output logic              slot_chan,
  output logic [WORD_W-1:0] slot_word,
  output logic [CNT_W-1:0]  slot_len
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WORD_W);
  localparam logic [CNT_W-1:0] MSB_POS  = CNT_W'(WORD_W - 1);

  logic              ws_q_r;
  logic [CNT_W-1:0]  bit_cnt_r;
  logic [WORD_W-1:0] shift_r;
  logic              ws_edge_s;
  logic [WORD_W-1:0] appended_s;

  // Slot completion view: the bit on the WS-change edge is the LSB of the ending slot.
  always_comb begin
    ws_edge_s  = (i2s_ws != ws_q_r);
    appended_s = {shift_r[WORD_W-2:0], i2s_data};
    if (bit_cnt_r < FULL_CNT) begin
      slot_word = appended_s << (MSB_POS - bit_cnt_r);
    end else begin
      slot_word = shift_r;
    end
    slot_done = ws_edge_s;
    slot_chan = ws_q_r;
    slot_len  = bit_cnt_r + CNT_W'(1);
  end

  // Shift register and saturating bit counter for the slot in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      ws_q_r    <= 1'b0;
      bit_cnt_r <= '0;
      shift_r   <= '0;
    end else begin
      ws_q_r <= i2s_ws;
      if (ws_edge_s) begin
        bit_cnt_r <= '0;
        shift_r   <= '0;
      end else if (bit_cnt_r < FULL_CNT) begin
        bit_cnt_r <= bit_cnt_r + CNT_W'(1);
        shift_r   <= {shift_r[WORD_W-2:0], i2s_data};
      end else begin
        bit_cnt_r <= bit_cnt_r;
        shift_r   <= shift_r;
      end
    end
  end

endmodule

// File: rtl/i2s_word_rx.sv
// I2S word receiver: deserialises slots, locks on a left-slot sync word and
// delivers numbered data words with a one-cycle valid strobe.
module i2s_word_rx
  import i2s_pkg::*;
#(
  parameter int          WORD_W    = I2S_WORD_W,
  parameter int          IDX_W     = I2S_IDX_W,
  parameter logic [31:0] SYNC_WORD = I2S_SYNC_WORD
) (
  input  logic              i2s_clk,
  input  logic              rst,
  input  logic              i2s_ws,
  input  logic              i2s_data,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic              word_chan,
  output logic [IDX_W-1:0]  word_idx,
  output logic              frame_start,
  output logic              locked,
  output logic              fmt_err
);

  localparam int                CNT_W    = $clog2(WORD_W + 2);
  localparam logic [CNT_W-1:0]  FULL_LEN = CNT_W'(WORD_W);
  localparam logic [WORD_W-1:0] SYNC_VAL = SYNC_WORD[WORD_W-1:0];

  logic              slot_done_s;
  logic              slot_chan_s;
  logic [WORD_W-1:0] slot_word_s;
  logic [CNT_W-1:0]  slot_len_s;
  logic              len_ok_s;
  logic              sync_s;

  rx_state_e         state_r;
  logic              pend_start_r;
  logic [IDX_W-1:0]  idx_cnt_r;

  i2s_slot_shifter #(
    .WORD_W (WORD_W),
    .CNT_W  (CNT_W)
  ) u_shifter (
    .clk       (i2s_clk),
    .rst       (rst),
    .i2s_ws    (i2s_ws),
    .i2s_data  (i2s_data),
    .slot_done (slot_done_s),
    .slot_chan (slot_chan_s),
    .slot_word (slot_word_s),
    .slot_len  (slot_len_s)
  );

  // Slot classification; a sync word only counts in a full-length left slot.
  always_comb begin
    len_ok_s = (slot_len_s == FULL_LEN);
    sync_s   = len_ok_s && (slot_word_s == SYNC_VAL) && (slot_chan_s == CHAN_LEFT);
  end

  // Lock tracking, word numbering and registered delivery outputs.
  always_ff @(posedge i2s_clk) begin
    if (rst) begin
      state_r      <= RX_UNPRIMED;
      pend_start_r <= 1'b0;
      idx_cnt_r    <= '0;
      word_data    <= '0;
      word_valid   <= 1'b0;
      word_chan    <= 1'b0;
      word_idx     <= '0;
      frame_start  <= 1'b0;
      locked       <= 1'b0;
      fmt_err      <= 1'b0;
    end else begin
      word_valid  <= 1'b0;
      frame_start <= 1'b0;
      fmt_err     <= 1'b0;
      if (slot_done_s) begin
        case (state_r)
          // The first slot after reset is partial and is thrown away.
          RX_UNPRIMED: begin
            state_r <= RX_HUNT;
          end
          RX_HUNT, RX_LOCKED: begin
            if (!len_ok_s) begin
              fmt_err      <= 1'b1;
              locked       <= 1'b0;
              pend_start_r <= 1'b0;
              state_r      <= RX_HUNT;
            end else if (sync_s) begin
              locked       <= 1'b1;
              pend_start_r <= 1'b1;
              idx_cnt_r    <= '0;
              state_r      <= RX_LOCKED;
            end else if (state_r == RX_LOCKED) begin
              word_valid   <= 1'b1;
              word_data    <= slot_word_s;
              word_chan    <= slot_chan_s;
              word_idx     <= idx_cnt_r;
              frame_start  <= pend_start_r;
              pend_start_r <= 1'b0;
              idx_cnt_r    <= idx_cnt_r + IDX_W'(1);
            end else begin
              state_r <= RX_HUNT;
            end
          end
          default: begin
            state_r      <= RX_UNPRIMED;
            locked       <= 1'b0;
            pend_start_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule

// File: tb/tb_i2s_word_rx.sv
// Self-checking bench for i2s_word_rx: directed framing scenarios followed by
// random slots, checked against a slot-level reference model.
module tb_i2s_word_rx;

  localparam logic [31:0] SYNC = 32'hA5A5_5A5A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i2s_ws = 1'b0;
  logic        i2s_data = 1'b0;

  logic [31:0] word_data;
  logic        word_valid, word_chan, frame_start, locked, fmt_err;
  logic [15:0] word_idx;

  logic [31:0] word_data4;
  logic        word_valid4, word_chan4, frame_start4, locked4, fmt_err4;
  logic [3:0]  word_idx4;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit          m_primed, m_locked, m_pend;
  logic [31:0] m_cnt;
  logic        e_valid, e_fs, e_err, e_chan;
  logic [31:0] e_data, e_idx;

  always #5 clk = ~clk;

  i2s_word_rx u_dut (
    .i2s_clk(clk), .rst(rst), .i2s_ws(i2s_ws), .i2s_data(i2s_data),
    .word_data(word_data), .word_valid(word_valid), .word_chan(word_chan),
    .word_idx(word_idx), .frame_start(frame_start), .locked(locked), .fmt_err(fmt_err)
  );

  i2s_word_rx #(.IDX_W(4)) u_dut4 (
    .i2s_clk(clk), .rst(rst), .i2s_ws(i2s_ws), .i2s_data(i2s_data),
    .word_data(word_data4), .word_valid(word_valid4), .word_chan(word_chan4),
    .word_idx(word_idx4), .frame_start(frame_start4), .locked(locked4), .fmt_err(fmt_err4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_primed = 1'b0; m_locked = 1'b0; m_pend = 1'b0; m_cnt = 32'd0;
    e_valid = 1'b0; e_fs = 1'b0; e_err = 1'b0; e_chan = 1'b0;
    e_data = 32'd0; e_idx = 32'd0;
  endtask

  task automatic model_quiet();
    e_valid = 1'b0; e_fs = 1'b0; e_err = 1'b0;
  endtask

  // One completed slot, judged from its channel, content and length.
  task automatic model_slot(input logic chan, input logic [31:0] word, input int len);
    model_quiet();
    if (!m_primed) begin
      m_primed = 1'b1;
    end else if (len != 32) begin
      e_err = 1'b1; m_locked = 1'b0; m_pend = 1'b0;
    end else if (word == SYNC && chan == 1'b0) begin
      m_locked = 1'b1; m_pend = 1'b1; m_cnt = 32'd0;
    end else if (m_locked) begin
      e_valid = 1'b1; e_data = word; e_chan = chan; e_idx = m_cnt; e_fs = m_pend;
      m_pend = 1'b0; m_cnt = m_cnt + 32'd1;
    end
  endtask

  task automatic check_all();
    chk("valid",        32'(word_valid),   32'(e_valid));
    chk("frame_start",  32'(frame_start),  32'(e_fs));
    chk("fmt_err",      32'(fmt_err),      32'(e_err));
    chk("locked",       32'(locked),       32'(m_locked));
    chk("word_data",    word_data,         e_data);
    chk("word_chan",    32'(word_chan),    32'(e_chan));
    chk("word_idx",     32'(word_idx),     32'(e_idx[15:0]));
    chk("valid4",       32'(word_valid4),  32'(e_valid));
    chk("frame_start4", 32'(frame_start4), 32'(e_fs));
    chk("fmt_err4",     32'(fmt_err4),     32'(e_err));
    chk("locked4",      32'(locked4),      32'(m_locked));
    chk("word_data4",   word_data4,        e_data);
    chk("word_chan4",   32'(word_chan4),   32'(e_chan));
    chk("word_idx4",    32'(word_idx4),    32'(e_idx[3:0]));
  endtask

  task automatic drive_bit(input logic ws_v, input logic d_v, input logic rst_v);
    @(negedge clk);
    i2s_ws = ws_v; i2s_data = d_v; rst = rst_v;
    @(posedge clk);
    #1;
  endtask

  // Sends one slot MSB first; its LSB goes out with WS already flipped.
  task automatic send_slot(input logic chan, input logic [31:0] word, input int len, input int rst_at);
    for (int i = 0; i < len; i++) begin
      logic b, w, r;
      b = (i < 32) ? word[31-i] : logic'($urandom_range(0, 1));
      w = (i == len - 1) ? ~chan : chan;
      r = (i == rst_at);
      drive_bit(w, b, r);
      if (r) model_reset();
      else if (i == len - 1) model_slot(chan, word, len);
      else model_quiet();
      check_all();
    end
  endtask

  initial begin
    logic        ch;
    logic [31:0] w;
    int          len, pick;
    model_reset();
    repeat (3) begin
      drive_bit(1'b0, 1'b0, 1'b1);
      model_reset();
      check_all();
    end

    // partial slot, unlocked data, sync, first word
    send_slot(1'b0, $urandom, 10, -1);
    send_slot(1'b1, $urandom, 32, -1);
    send_slot(1'b0, SYNC, 32, -1);
    send_slot(1'b1, 32'h0000_0001, 32, -1);

    // resync then four numbered words
    send_slot(1'b0, SYNC, 32, -1);
    for (int n = 1; n <= 4; n++)
      send_slot((n % 2 == 1) ? 1'b1 : 1'b0, 32'(32'h1111_1111 * n), 32, -1);

    // short slot drops lock until the next sync
    send_slot(1'b1, $urandom, 31, -1);
    send_slot(1'b0, $urandom, 32, -1);
    send_slot(1'b1, $urandom, 32, -1);
    send_slot(1'b0, SYNC, 32, -1);
    send_slot(1'b1, $urandom, 32, -1);

    // sync pattern in a right slot is ordinary data
    send_slot(1'b0, $urandom, 32, -1);
    send_slot(1'b1, SYNC, 32, -1);

    // index wrap on the narrow instance
    send_slot(1'b0, SYNC, 32, -1);
    for (int n = 0; n < 18; n++)
      send_slot((n % 2 == 0) ? 1'b1 : 1'b0, $urandom, 32, -1);

    // reset mid-frame, then re-prime and resync
    send_slot(1'b1, $urandom, 32, -1);
    send_slot(1'b0, $urandom, 32, 10);
    send_slot(1'b1, $urandom, 32, -1);
    send_slot(1'b0, SYNC, 32, -1);
    send_slot(1'b1, $urandom, 32, -1);

    // random slots, mostly well-formed, some sync words and bad lengths
    ch = 1'b0;
    for (int n = 0; n < 60; n++) begin
      pick = $urandom_range(0, 19);
      case (pick)
        0:       len = 31;
        1:       len = 20;
        2:       len = 33;
        3:       len = 80;
        default: len = 32;
      endcase
      w = (ch == 1'b0 && $urandom_range(0, 4) == 0) ? SYNC : 32'($urandom);
      send_slot(ch, w, len, -1);
      ch = ~ch;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
